a2d_scan_intf: RTL and testbench

//  Parametrised successor to the single-shot A2D SPI interface. Runs 1-of-N channel conversions on an

---
 rtl/a2d_pkg.sv | 25 ++
 rtl/SPI_mstr.sv | 63 ++++++
 rtl/a2d_scan_intf.sv | 186 ++++++++++++++++++
 tb/tb_a2d_scan_intf.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the scanning 8-channel SPI A2D interface.
// Holds the controller state encoding, the pending-request record and the A2D command format.
package a2d_pkg;

  localparam int A2D_CMD_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    GAP,
    READ,
    ACCUM
  } a2d_state_t;

  typedef struct packed {
    logic       vld;
    logic [2:0] chnl;
  } cnv_req_t;

  // Channel select sits in bits [13:11]; the same word is sent for the select and read frames.
  function automatic logic [A2D_CMD_W-1:0] a2d_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/SPI_mstr.sv
// 16-bit mode-0 SPI master: one frame per wrt pulse, SCLK = clk/8, done pulses once per frame.
// rd_data holds the received word until the next frame starts.
module SPI_mstr
  import a2d_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wrt,
  input  logic [A2D_CMD_W-1:0] cmd,
  output logic                 done,
  output logic [A2D_CMD_W-1:0] rd_data,
  output logic                 SS_n,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO
);

  logic                 active;
  logic [2:0]           div;
  logic [3:0]           bit_cnt;
  logic [A2D_CMD_W-1:0] shft;
  logic                 miso_smpl;

  // SCLK is low for div 0..3 and high for 4..7; MISO is sampled as SCLK rises, shifted as it falls.
  assign SCLK    = active & div[2];
  assign MOSI    = shft[A2D_CMD_W-1];
  assign rd_data = shft;

  // NOTE: every register in a clocked block uses <= so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      div       <= '0;
      bit_cnt   <= '0;
      shft      <= '0;
      miso_smpl <= 1'b0;
      SS_n      <= 1'b1;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (wrt && !active) begin
        active  <= 1'b1;
        SS_n    <= 1'b0;
        shft    <= cmd;
        div     <= '0;
        bit_cnt <= '0;
      end else if (active) begin
        div <= div + 3'd1;
        if (div == 3'd3) miso_smpl <= MISO;
        if (div == 3'd7) begin
          shft    <= {shft[A2D_CMD_W-2:0], miso_smpl};
          bit_cnt <= bit_cnt + 4'd1;
          if (bit_cnt == 4'd15) begin
            active <= 1'b0;
            SS_n   <= 1'b1;
            done   <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/a2d_scan_intf.sv
// Multi-channel A2D front end: single or round-robin scan conversions, 2**AVG_LOG2-sample
// averaging, and a per-channel result bank readable combinationally.
module a2d_scan_intf
  import a2d_pkg::*;
#(
  parameter int NUM_CHNL = 8,
  parameter int RES_W    = 12,
  parameter int AVG_LOG2 = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                strt_cnv,
  input  logic [2:0]          chnnl,
  input  logic                scan_en,
  input  logic [2:0]          rd_chnl,
  output logic [RES_W-1:0]    rd_res,
  output logic [NUM_CHNL-1:0] bank_vld,
  output logic [RES_W-1:0]    res,
  output logic [2:0]          res_chnl,
  output logic                cnv_cmplt,
  output logic                scan_wrap,
  output logic                busy,
  output logic                a2d_SS_n,
  output logic                SCLK,
  output logic                MOSI,
  input  logic                MISO
);

  localparam int               ACC_W     = RES_W + AVG_LOG2;
  localparam int               CNT_W     = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] LAST_SMPL = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [2:0]       LAST_CHNL = 3'(NUM_CHNL - 1);

  a2d_state_t           state, nxt_state;
  cnv_req_t             pend;
  logic [2:0]           cur_chnl, scan_ptr, start_chnl;
  logic                 cur_single;
  logic [ACC_W-1:0]     acc, acc_sum;
  logic [CNT_W-1:0]     smpl_cnt;
  logic [RES_W-1:0]     bank [NUM_CHNL];
  logic [RES_W-1:0]     avg_res;
  logic                 wrt, done, wrt_sent;
  logic [A2D_CMD_W-1:0] rd_data;
  logic                 start, start_single, take_pend, last_smpl, finish;

  SPI_mstr u_spi (
    .clk     (clk),
    .rst_n   (rst_n),
    .wrt     (wrt),
    .cmd     (a2d_cmd(cur_chnl)),
    .done    (done),
    .rd_data (rd_data),
    .SS_n    (a2d_SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  if (RES_W < A2D_CMD_W) begin : g_rd_unused
    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_data[A2D_CMD_W-1:RES_W];
  end

  // rd_data still holds the READ frame while in ACCUM, so the sample is added straight from it.
  assign acc_sum   = acc + ACC_W'(rd_data[RES_W-1:0]);
  assign avg_res   = RES_W'(acc_sum >> AVG_LOG2);
  assign last_smpl = (smpl_cnt == LAST_SMPL);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    nxt_state    = state;
    wrt          = 1'b0;
    start        = 1'b0;
    start_single = 1'b0;
    start_chnl   = scan_ptr;
    take_pend    = 1'b0;
    finish       = 1'b0;
    case (state)
      IDLE: begin
        if (pend.vld) begin
          start        = 1'b1;
          start_single = 1'b1;
          start_chnl   = pend.chnl;
          take_pend    = 1'b1;
          nxt_state    = CMD;
        end else if (strt_cnv) begin
          start        = 1'b1;
          start_single = 1'b1;
          start_chnl   = chnnl;
          nxt_state    = CMD;
        end else if (scan_en) begin
          start     = 1'b1;
          nxt_state = CMD;
        end
      end
      CMD: begin
        wrt = !wrt_sent;
        if (done) nxt_state = GAP;
      end
      GAP: nxt_state = READ;
      READ: begin
        wrt = !wrt_sent;
        if (done) nxt_state = ACCUM;
      end
      ACCUM: begin
        if (last_smpl) begin
          finish    = 1'b1;
          nxt_state = IDLE;
        end else begin
          nxt_state = CMD;
        end
      end
      default: nxt_state = IDLE;
    endcase
  end

  // NOTE: the bank is a handful of words held in flops, so it is cleared by reset like any other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend       <= '0;
      wrt_sent   <= 1'b0;
      cur_chnl   <= '0;
      cur_single <= 1'b0;
      scan_ptr   <= '0;
      acc        <= '0;
      smpl_cnt   <= '0;
      res        <= '0;
      res_chnl   <= '0;
      cnv_cmplt  <= 1'b0;
      scan_wrap  <= 1'b0;
      bank_vld   <= '0;
      for (int i = 0; i < NUM_CHNL; i++) bank[i] <= '0;
    end else begin
      cnv_cmplt <= 1'b0;
      scan_wrap <= 1'b0;

      // One request can wait behind a running conversion; any further request is dropped.
      if (take_pend)
        pend <= '0;
      else if (busy && strt_cnv && !pend.vld)
        pend <= '{vld: 1'b1, chnl: chnnl};

      if (done)     wrt_sent <= 1'b0;
      else if (wrt) wrt_sent <= 1'b1;

      if (start) begin
        cur_chnl   <= start_chnl;
        cur_single <= start_single;
        acc        <= '0;
        smpl_cnt   <= '0;
      end else if (state == ACCUM) begin
        acc      <= acc_sum;
        smpl_cnt <= smpl_cnt + CNT_W'(1);
      end

      if (finish) begin
        res       <= avg_res;
        res_chnl  <= cur_chnl;
        cnv_cmplt <= cur_single;
        for (int i = 0; i < NUM_CHNL; i++) begin
          if (cur_chnl == 3'(i)) begin
            bank[i]     <= avg_res;
            bank_vld[i] <= 1'b1;
          end
        end
        if (!cur_single) begin
          scan_wrap <= (scan_ptr == LAST_CHNL);
          scan_ptr  <= (scan_ptr == LAST_CHNL) ? 3'd0 : scan_ptr + 3'd1;
        end
      end
    end
  end

  always_comb begin
    rd_res = '0;
    for (int i = 0; i < NUM_CHNL; i++)
      if (rd_chnl == 3'(i)) rd_res = bank[i];
  end

endmodule

// File: tb/tb_a2d_scan_intf.sv
// Scoreboard bench for a2d_scan_intf with a behavioural SPI A2D that answers 12'h100*ch + sample_idx.
// Expected conversions are queued when requested and retired when busy falls.
module tb_a2d_scan_intf;

  localparam int NUM_CHNL   = 6;
  localparam int RES_W      = 12;
  localparam int AVG_LOG2   = 2;
  localparam int SMPLS      = 1 << AVG_LOG2;
  localparam int CNV_BUDGET = 2 * SMPLS * 140 + 50;

  typedef struct {
    logic [2:0]       chnl;
    logic [RES_W-1:0] res;
    logic             single;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                strt_cnv = 1'b0;
  logic [2:0]          chnnl = '0;
  logic                scan_en = 1'b0;
  logic [2:0]          rd_chnl = '0;
  logic [RES_W-1:0]    rd_res;
  logic [NUM_CHNL-1:0] bank_vld;
  logic [RES_W-1:0]    res;
  logic [2:0]          res_chnl;
  logic                cnv_cmplt, scan_wrap, busy;
  logic                a2d_SS_n, a2d_SCLK, a2d_MOSI, a2d_MISO;

  int n_checks = 0;
  int n_fail   = 0;

  exp_t                exp_q[$];
  exp_t                mon_e;
  logic [NUM_CHNL-1:0] exp_vld = '0;
  logic [RES_W-1:0]    exp_bank [8];
  int                  exp_singles = 0, exp_wraps = 0;
  int                  cmplt_cnt = 0, wrap_cnt = 0, cnv_count = 0;
  logic                busy_q = 1'b0;
  int                  frames_at_last = 0;

  // A2D model state
  logic [15:0] tx_word = '0, rx_word = '0, cmd_word = '0, last_cmd = '0;
  logic [2:0]  sel_chnl = '0;
  int          frame_cnt = 0, rd_idx = 0;

  a2d_scan_intf #(.NUM_CHNL(NUM_CHNL), .RES_W(RES_W), .AVG_LOG2(AVG_LOG2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .strt_cnv  (strt_cnv),
    .chnnl     (chnnl),
    .scan_en   (scan_en),
    .rd_chnl   (rd_chnl),
    .rd_res    (rd_res),
    .bank_vld  (bank_vld),
    .res       (res),
    .res_chnl  (res_chnl),
    .cnv_cmplt (cnv_cmplt),
    .scan_wrap (scan_wrap),
    .busy      (busy),
    .a2d_SS_n  (a2d_SS_n),
    .SCLK      (a2d_SCLK),
    .MOSI      (a2d_MOSI),
    .MISO      (a2d_MISO)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [RES_W-1:0] exp_res(input logic [2:0] ch);
    int sum = 0;
    for (int i = 0; i < SMPLS; i++) sum += (256 * int'(ch) + i) & ((1 << RES_W) - 1);
    return RES_W'(sum >> AVG_LOG2);
  endfunction

  // ---------------- A2D model ----------------
  assign a2d_MISO = tx_word[15];

  initial begin
    forever begin
      @(negedge a2d_SS_n);
      tx_word = (frame_cnt % 2 == 1) ? 16'(256 * int'(sel_chnl) + rd_idx) : 16'h0000;
      while (!a2d_SS_n) begin
        @(negedge a2d_SCLK or posedge a2d_SS_n);
        tx_word = {tx_word[14:0], 1'b0};
      end
    end
  end

  always @(posedge a2d_SCLK) rx_word = {rx_word[14:0], a2d_MOSI};

  always @(posedge a2d_SS_n or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt = 0;
      rd_idx    = 0;
    end else begin
      if (frame_cnt % 2 == 0) begin
        cmd_word = rx_word;
        sel_chnl = rx_word[13:11];
      end else begin
        check("rd_frame_cmd", rx_word, cmd_word);
        last_cmd = rx_word;
        rd_idx   = (rd_idx + 1) % SMPLS;
      end
      frame_cnt++;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_q         = 1'b0;
      frames_at_last = 0;
      exp_vld        = '0;
      for (int i = 0; i < 8; i++) exp_bank[i] = '0;
    end else begin
      if (cnv_cmplt) cmplt_cnt++;
      if (scan_wrap) wrap_cnt++;
      if (busy_q && !busy) begin
        cnv_count++;
        check("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          check("res", res, mon_e.res);
          check("res_chnl", res_chnl, mon_e.chnl);
          check("cnv_cmplt", cnv_cmplt, mon_e.single);
          check("scan_wrap", scan_wrap, !mon_e.single && mon_e.chnl == 3'(NUM_CHNL - 1));
          check("frames", frame_cnt - frames_at_last, 2 * SMPLS);
          check("cmd_word", last_cmd, {2'b00, mon_e.chnl, 11'h000});
          if (int'(mon_e.chnl) < NUM_CHNL) begin
            exp_vld[mon_e.chnl]  = 1'b1;
            exp_bank[mon_e.chnl] = mon_e.res;
          end
          check("bank_vld", bank_vld, exp_vld);
        end
        frames_at_last = frame_cnt;
      end
      busy_q = busy;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_exp(input logic [2:0] ch, input logic single);
    exp_q.push_back('{chnl: ch, res: exp_res(ch), single: single});
    if (single) exp_singles++;
    else if (ch == 3'(NUM_CHNL - 1)) exp_wraps++;
  endtask

  task automatic pulse_strt(input logic [2:0] ch);
    @(negedge clk);
    chnnl    = ch;
    strt_cnv = 1'b1;
    @(negedge clk);
    strt_cnv = 1'b0;
  endtask

  task automatic wait_cnv(input int n);
    int target = cnv_count + n;
    int cyc    = 0;
    while (cnv_count < target && cyc < n * CNV_BUDGET) begin
      @(negedge clk);
      cyc++;
    end
    check("cnv_timeout", cnv_count >= target, 1);
  endtask

  task automatic wait_busy();
    int cyc = 0;
    while (!busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("busy_timeout", busy, 1);
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rd_chnl = 3'(i);
      #1;
      check(tag, rd_res, exp_bank[i]);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(negedge clk);
    check("rst_ss_n", a2d_SS_n, 1);
    check("rst_busy", busy, 0);
    check("rst_bank_vld", bank_vld, 0);
    check("rst_res", res, 0);
    check("rst_cnv_cmplt", cnv_cmplt, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single conversions: in range, top in-range channel, out of range
    push_exp(3'd3, 1'b1);
    pulse_strt(3'd3);
    check("busy_accept", busy, 1);
    wait_cnv(1);
    push_exp(3'd5, 1'b1);
    pulse_strt(3'd5);
    wait_cnv(1);
    push_exp(3'd7, 1'b1);
    pulse_strt(3'd7);
    wait_cnv(1);
    check("vld_out_of_range", bank_vld, 6'b101000);

    // full scan, scan_en dropped during the last channel
    for (int c = 0; c < NUM_CHNL; c++) push_exp(3'(c), 1'b0);
    @(negedge clk);
    scan_en = 1'b1;
    wait_cnv(NUM_CHNL - 1);
    wait_busy();
    scan_en = 1'b0;
    wait_cnv(1);
    check_bank("rd_res_scan");

    // single request arriving mid-scan
    push_exp(3'd0, 1'b0);
    push_exp(3'd1, 1'b0);
    push_exp(3'd6, 1'b1);
    push_exp(3'd2, 1'b0);
    @(negedge clk);
    scan_en = 1'b1;
    wait_cnv(1);
    wait_busy();
    repeat (50) @(negedge clk);
    pulse_strt(3'd6);
    wait_cnv(2);
    wait_busy();
    scan_en = 1'b0;
    wait_cnv(1);
    repeat (300) @(negedge clk);
    check("idle_after_scan", busy, 0);

    // second request while busy is dropped
    push_exp(3'd1, 1'b1);
    push_exp(3'd2, 1'b1);
    pulse_strt(3'd1);
    repeat (20) @(negedge clk);
    pulse_strt(3'd2);
    repeat (20) @(negedge clk);
    pulse_strt(3'd7);
    wait_cnv(2);
    repeat (300) @(negedge clk);
    check("idle_after_drop", busy, 0);

    // reset in the middle of a READ frame
    pulse_strt(3'd2);
    begin
      int cyc = 0;
      while (!(frame_cnt % 2 == 1 && !a2d_SS_n) && cyc < CNV_BUDGET) begin
        @(negedge clk);
        cyc++;
      end
      check("read_frame_seen", !a2d_SS_n, 1);
    end
    repeat (30) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_ss_n", a2d_SS_n, 1);
    check("abort_busy", busy, 0);
    check("abort_bank_vld", bank_vld, 0);
    check("abort_res", res, 0);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    rd_chnl = 3'd3;
    #1;
    check("abort_rd_res", rd_res, 0);
    push_exp(3'd4, 1'b1);
    pulse_strt(3'd4);
    wait_cnv(1);
    check_bank("rd_res_final");

    repeat (20) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("cmplt_pulses", cmplt_cnt, exp_singles);
    check("wrap_pulses", wrap_cnt, exp_wraps);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
